hazard_scoreboard: RTL and testbench

//  Per-register scoreboard for the dynamic pipeline; replaces fixed per-stage load-use compare logic.

---
 rtl/hazard_scoreboard.sv | 186 ++++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//   Per-register scoreboard for the dynamic pipeline. It sits between IF/ID and
//   ID/EXE. Each issued register writer arms a countdown equal to its result
//   latency, which is the number of cycles until the result can be forwarded.
//   The instruction at ID is stalled while any source register it reads has a
//   nonzero count. The stall holds IF/ID and injects a bubble into ID/EXE.
//
// Optional feature (compile-time macro HAZ_PERF_CNT_EN):
//   When the macro is defined, the block adds perf_clr and stall_cycles. These
//   implement a saturating count of stall cycles. When the macro is undefined,
//   neither port nor any counter logic exists.
//
// Ports
//   clk            in   1     system clock, rising edge
//   rst_n          in   1     synchronous active-low reset
//   issue_valid    in   1     ID holds a valid instruction requesting issue
//   issue_rs       in   AW    source 1 address
//   issue_rs_used  in   1     source 1 is read
//   issue_rt       in   AW    source 2 address
//   issue_rt_used  in   1     source 2 is read
//   issue_we       in   1     instruction writes the register file
//   issue_waddr    in   AW    destination address
//   issue_lat      in   CW    cycles until result forwardable (0 = immediate)
//   flush          in   1     kill the instruction at ID this cycle
//   stall          out  1     hold IF/ID, bubble into ID/EXE (combinational)
//   issue_fire     out  1     issue_valid & ~stall & ~flush
//   busy           out  NREG  busy[r] = (cnt[r] != 0), busy[0] = 0
//   perf_clr       in   1     clear stall_cycles       (HAZ_PERF_CNT_EN only)
//   stall_cycles   out  32    saturating stall count   (HAZ_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int NREG    = 32,
    parameter int AW      = 5,
    parameter int MAX_LAT = 3,
    parameter int CW      = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rs,
    input  logic            issue_rs_used,
    input  logic [AW-1:0]   issue_rt,
    input  logic            issue_rt_used,
    input  logic            issue_we,
    input  logic [AW-1:0]   issue_waddr,
    input  logic [CW-1:0]   issue_lat,
    input  logic            flush,
`ifdef HAZ_PERF_CNT_EN
    input  logic            perf_clr,
    output logic [31:0]     stall_cycles,
`endif
    output logic            stall,
    output logic            issue_fire,
    output logic [NREG-1:0] busy
);

    // Count one lower, floored at zero.
    function automatic logic [CW-1:0] dec_cnt(input logic [CW-1:0] c);
        logic [CW-1:0] r;
        if (c == {CW{1'b0}}) begin
            r = {CW{1'b0}};
        end else begin
            r = c - {{(CW-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    // Latencies above MAX_LAT saturate to MAX_LAT.
    function automatic logic [CW-1:0] sat_lat(input logic [CW-1:0] l);
        logic [CW-1:0] r;
        if (int'(l) > MAX_LAT) begin
            r = CW'(MAX_LAT);
        end else begin
            r = l;
        end
        return r;
    endfunction

    // Larger of two counts.
    function automatic logic [CW-1:0] max_cnt(input logic [CW-1:0] a, input logic [CW-1:0] b);
        logic [CW-1:0] r;
        if (a > b) begin
            r = a;
        end else begin
            r = b;
        end
        return r;
    endfunction

    logic [CW-1:0] cnt_q [NREG];
    logic [CW-1:0] cnt_d [NREG];
    logic [CW-1:0] lat_eff_s;
    logic          rs_hit_s;
    logic          rt_hit_s;
    logic          arm_s;

    // Source hazard check. It uses the pre-update counts, so a self-dependent
    // instruction sees only the older writers.
    always_comb begin
        rs_hit_s = 1'b0;
        rt_hit_s = 1'b0;
        if (issue_rs_used && (issue_rs != {AW{1'b0}}) && (cnt_q[issue_rs] != {CW{1'b0}})) begin
            rs_hit_s = 1'b1;
        end else begin
            rs_hit_s = 1'b0;
        end
        if (issue_rt_used && (issue_rt != {AW{1'b0}}) && (cnt_q[issue_rt] != {CW{1'b0}})) begin
            rt_hit_s = 1'b1;
        end else begin
            rt_hit_s = 1'b0;
        end
    end

    // Flush does not gate stall. It only suppresses issue and counter arming.
    assign stall      = issue_valid & (rs_hit_s | rt_hit_s);
    assign issue_fire = issue_valid & ~stall & ~flush;
    assign lat_eff_s  = sat_lat(issue_lat);
    assign arm_s      = issue_fire & issue_we & (lat_eff_s != {CW{1'b0}});

    // Next count per register. The max() keeps a short WAW writer from hiding an
    // older, longer pending write. Register 0 never becomes busy.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = {CW{1'b0}};
            if (r == 0) begin
                cnt_d[r] = {CW{1'b0}};
            end else if (arm_s && (issue_waddr == AW'(r))) begin
                cnt_d[r] = max_cnt(dec_cnt(cnt_q[r]), lat_eff_s);
            end else begin
                cnt_d[r] = dec_cnt(cnt_q[r]);
            end
        end
    end

    // Counter array register. Reset drops every pending count.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NREG; r++) begin
            if (!rst_n) begin
                cnt_q[r] <= {CW{1'b0}};
            end else begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // Busy vector decoded from the counts.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            if (r == 0) begin
                busy[r] = 1'b0;
            end else begin
                busy[r] = (cnt_q[r] != {CW{1'b0}});
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;

    // Saturating stall-cycle count. A clear takes priority over an increment.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (perf_clr) begin
            stall_cycles_d = 32'h0000_0000;
        end else if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'h0000_0001;
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
    end

    // Stall-cycle count register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles_q <= 32'h0000_0000;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//   Directed bench for hazard_scoreboard. Inputs change 1 time unit after each
//   rising edge. Combinational outputs are sampled 1 unit later. Registered
//   state (busy) is sampled 1 unit after an edge.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic [4:0]  issue_rs;
    logic        issue_rs_used;
    logic [4:0]  issue_rt;
    logic        issue_rt_used;
    logic        issue_we;
    logic [4:0]  issue_waddr;
    logic [1:0]  issue_lat;
    logic        flush;
    logic        stall;
    logic        issue_fire;
    logic [31:0] busy;
`ifdef HAZ_PERF_CNT_EN
    logic        perf_clr;
    logic [31:0] stall_cycles;
`endif

    int checks;
    int errors;

    hazard_scoreboard dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid   (issue_valid),
        .issue_rs      (issue_rs),
        .issue_rs_used (issue_rs_used),
        .issue_rt      (issue_rt),
        .issue_rt_used (issue_rt_used),
        .issue_we      (issue_we),
        .issue_waddr   (issue_waddr),
        .issue_lat     (issue_lat),
        .flush         (flush),
`ifdef HAZ_PERF_CNT_EN
        .perf_clr      (perf_clr),
        .stall_cycles  (stall_cycles),
`endif
        .stall         (stall),
        .issue_fire    (issue_fire),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic rsu,
                         input logic [4:0] rt, input logic rtu, input logic we,
                         input logic [4:0] wa, input logic [1:0] lat, input logic fl);
        issue_valid   = v;
        issue_rs      = rs;
        issue_rs_used = rsu;
        issue_rt      = rt;
        issue_rt_used = rtu;
        issue_we      = we;
        issue_waddr   = wa;
        issue_lat     = lat;
        flush         = fl;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
`ifdef HAZ_PERF_CNT_EN
        perf_clr = 1'b0;
`endif
        // T1: reset with a valid writer presented
        rst_n = 1'b0;
        drive(1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b1, 5'd8, 2'd3, 1'b0);
        cyc();
        cyc();
        chk("t1_busy_in_reset", busy, 32'h0000_0000);
        chk("t1_stall_in_reset", {31'd0, stall}, 32'd0);
        rst_n = 1'b1;
        idle();
        cyc();
        chk("t1_busy_after_rel", busy, 32'h0000_0000);
        cyc();
        chk("t1_busy_after_rel2", busy, 32'h0000_0000);

        // T2: load-use, LW r8 lat 3 then ADD reading r8
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8, 2'd3, 1'b0);
        #1;
        chk("t2_lw_stall", {31'd0, stall}, 32'd0);
        chk("t2_lw_fire", {31'd0, issue_fire}, 32'd1);
        cyc();
        chk("t2_busy_armed", busy, 32'h0000_0100);
        drive(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b1, 5'd10, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("t2_stall_c%0d", i), {31'd0, stall}, 32'd1);
            chk($sformatf("t2_fire_c%0d", i), {31'd0, issue_fire}, 32'd0);
            chk($sformatf("t2_busy_c%0d", i), busy, 32'h0000_0100);
            cyc();
        end
        #1;
        chk("t2_release_stall", {31'd0, stall}, 32'd0);
        chk("t2_release_fire", {31'd0, issue_fire}, 32'd1);
        chk("t2_release_busy", busy, 32'h0000_0000);
        cyc();
        chk("t2_lat0_no_busy", busy, 32'h0000_0000);

        // T3: WAW, lat 3 then lat 1 to r5 -> count 2 remains
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 2'd3, 1'b0);
        cyc();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 2'd1, 1'b0);
        #1;
        chk("t3_second_fire", {31'd0, issue_fire}, 32'd1);
        cyc();
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
        #1;
        chk("t3_stall_c0", {31'd0, stall}, 32'd1);
        cyc();
        chk("t3_stall_c1", {31'd0, stall}, 32'd1);
        cyc();
        chk("t3_release_stall", {31'd0, stall}, 32'd0);
        chk("t3_release_busy", busy, 32'h0000_0000);

        // T4: writes to r0 ignored; an unused busy source does not stall
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 2'd3, 1'b0);
        #1;
        chk("t4_r0_fire", {31'd0, issue_fire}, 32'd1);
        cyc();
        chk("t4_r0_busy", busy, 32'h0000_0000);
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 2'd3, 1'b0);
        cyc();
        drive(1'b1, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
        #1;
        chk("t4_rt_unused_stall", {31'd0, stall}, 32'd0);
        chk("t4_r9_busy", busy, 32'h0000_0200);
        drive(1'b1, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0, 5'd0, 2'd0, 1'b0);
        #1;
        chk("t4_rt_used_stall", {31'd0, stall}, 32'd1);
        idle();
        cyc();
        cyc();
        cyc();
        chk("t4_drained", busy, 32'h0000_0000);

        // T5: flush suppresses arming, and flush during stall only decrements
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd12, 2'd3, 1'b1);
        #1;
        chk("t5_flush_fire", {31'd0, issue_fire}, 32'd0);
        chk("t5_flush_stall", {31'd0, stall}, 32'd0);
        cyc();
        chk("t5_flush_busy", busy, 32'h0000_0000);
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd13, 2'd3, 1'b0);
        cyc();
        drive(1'b1, 5'd13, 1'b1, 5'd0, 1'b0, 1'b1, 5'd14, 2'd3, 1'b1);
        #1;
        chk("t5_stall_with_flush", {31'd0, stall}, 32'd1);
        chk("t5_fire_with_flush", {31'd0, issue_fire}, 32'd0);
        cyc();
        chk("t5_dec_c1", busy, 32'h0000_2000);
        cyc();
        chk("t5_dec_c2", busy, 32'h0000_2000);
        cyc();
        chk("t5_dec_c3", busy, 32'h0000_0000);
        chk("t5_end_stall", {31'd0, stall}, 32'd0);
        chk("t5_end_fire", {31'd0, issue_fire}, 32'd0);
        idle();

        // Reset mid-operation drops pending counts
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd20, 2'd3, 1'b0);
        cyc();
        chk("rst_mid_armed", busy, 32'h0010_0000);
        idle();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("rst_mid_cleared", busy, 32'h0000_0000);

`ifdef HAZ_PERF_CNT_EN
        // T6: stall-cycle counter
        chk("t6_after_reset", stall_cycles, 32'd0);
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8, 2'd3, 1'b0);
        cyc();
        drive(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
        cyc();
        cyc();
        cyc();
        idle();
        chk("t6_count3", stall_cycles, 32'd3);
        perf_clr = 1'b1;
        cyc();
        perf_clr = 1'b0;
        chk("t6_cleared", stall_cycles, 32'd0);
        force dut.stall_cycles_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cycles_q;
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8, 2'd3, 1'b0);
        cyc();
        drive(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
        cyc();
        idle();
        chk("t6_saturate", stall_cycles, 32'hFFFF_FFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
